pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter FWD_EN, default 1: 1 = forward from M/W stages; 0 = no forwarding, RAW hazards resolved by stalling.
REQ-002 Parameter ILL_FLAG_EN, default 1: 1 = illegal_w reports undecodable instructions; 0 = illegal_w tied 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_d  in  32  RV32I instruction in the decode stage.
REQ-006 valid_d  in  1  instr_d holds a real instruction.
REQ-007 BrEq, BrLt  in  1 each  branch comparator results for the EX-stage operands.
REQ-008 ImmSel_d  out  3  immediate format for instr_d: I=0, B=1, U=2, J=3, S=4.
REQ-009 stall_fd  out  1  hold PC and the F/D register.
REQ-010 flush_d  out  1  kill the F/D register contents.
REQ-011 ASel_e, BSel_e, BrU_e, PCSel_e  out  1 each  EX-stage operand selects, unsigned compare, and redirect.
REQ-012 ALUSel_e  out  4  EX-stage ALU operation.
REQ-013 fwd_a_e, fwd_b_e  out  2 each  operand source: 00 = regfile, 01 = M result, 10 = W result.
REQ-014 MemRW_m  out  1  M-stage store enable.
REQ-015 RegWEn_w  out  1  W-stage register write enable.
REQ-016 WBSel_w  out  2  W-stage writeback source: 00 = ALU, 01 = DMEM, 10 = PC+4.
REQ-017 rd_w  out  5  W-stage destination register.
REQ-018 illegal_w  out  1  W-stage instruction was undecodable.

Function
REQ-019 Decode in D SHALL produce one control word per instruction:
  - ImmSel, ASel, BSel and ALUSel per the RV32I single-cycle control encoding: ALUSel = {instr[30], funct3} for R-type and shift-right immediates, {0, funct3} for other OP-IMM, 0000 otherwise.
  - rs1-used: R, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2-used: R, STORE, BRANCH.
REQ-020 The control word SHALL advance through the E, M and W registers, each register carrying a valid bit; MemRW_m and RegWEn_w SHALL be 0 when their stage is invalid.
REQ-021 RegWEn_w SHALL be 0 for STORE, BRANCH and whenever rd_w = 0.
REQ-022 Any unrecognised opcode SHALL decode as a NOP (no register write, no store) and carry an illegal bit through to illegal_w, where it is high for one cycle.
REQ-023 BrU_e SHALL be 1 iff E-stage funct3 is 110 or 111.
REQ-024 PCSel_e SHALL be combinational and 1 iff E is valid and one of:
  - JAL or JALR;
  - BRANCH taken: beq needs BrEq, bne !BrEq, blt/bltu BrLt, bge/bgeu !BrLt.
  - Other BRANCH funct3 values are never taken.
REQ-025 When PCSel_e = 1: flush_d = 1, the E register loads a bubble at the next edge, and stall_fd = 0.
REQ-026 Load-use hazard: E is a valid LOAD with rd_e != 0, and rd_e equals a used rs of a valid D instruction.
  - stall_fd = 1 for exactly one cycle.
  - E loads a bubble at the next edge.
REQ-027 With FWD_EN = 1, fwd_x_e SHALL be:
  - 01 if M is valid, writes a register, rd_m != 0 and rd_m = rs_x_e;
  - else 10 if the same conditions hold for W;
  - else 00.
  - M has priority over W.
REQ-028 With FWD_EN = 0, fwd outputs SHALL be 00, and stall_fd SHALL be 1 while a valid writing instruction in E or M has rd != 0 equal to a used rs of D.
  - The register file is write-before-read, so W is not a hazard.
REQ-029 Priority SHALL be redirect > stall. During a stall the M and W registers SHALL advance normally.
REQ-030 Pipeline control latency SHALL be:
  - D to E: 1 cycle;
  - E to M: 1 cycle;
  - M to W: 1 cycle.
REQ-031 An instruction with valid_d = 0 SHALL enter E as a bubble.

Reset
REQ-032 While rst_n = 0, all stage valid bits SHALL clear immediately.
REQ-033 While rst_n = 0, every registered output SHALL be 0; since all stages are invalid, PCSel_e, stall_fd, flush_d and fwd_* SHALL also read 0.
REQ-034 A reset mid-operation SHALL discard all in-flight instructions; the first valid_d after release SHALL reach W 3 cycles later.

Verification
REQ-035 addi x1,x0,5 then add x2,x1,x1 -> fwd_a_e = fwd_b_e = 01 in the add's E cycle; no stall; RegWEn_w = 1, rd_w = 2 three cycles later.
REQ-036 lw x3,0(x0) then add x4,x3,x0 -> stall_fd = 1 for 1 cycle with a bubble in E; the add then gets fwd_a_e = 10.
REQ-037 beq x0,x0 with BrEq = 1 -> PCSel_e = 1 and flush_d = 1 in the same cycle; the D instruction never reaches W (RegWEn_w = 0 in its slot); bne with BrEq = 1 -> PCSel_e = 0.
REQ-038 FWD_EN = 0, addi x5 then sub x6,x5,x5 -> stall_fd = 1 for 2 cycles; fwd outputs stay 00.
REQ-039 addi x0,x0,1 -> RegWEn_w = 0; opcode 0x7F -> illegal_w pulses 1 cycle, with MemRW_m = 0 and RegWEn_w = 0.
REQ-040 rst_n asserted with a store in M -> MemRW_m = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pipe_control.sv
// pipe_control: RV32I decode plus E/M/W control pipeline with
// forwarding, load-use / RAW stalls and branch/jump redirect.
module pipe_control #(
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned ILL_FLAG_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic [2:0]  ImmSel_d,
  output logic        stall_fd,
  output logic        flush_d,
  output logic        ASel_e,
  output logic        BSel_e,
  output logic        BrU_e,
  output logic        PCSel_e,
  output logic [3:0]  ALUSel_e,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        MemRW_m,
  output logic        RegWEn_w,
  output logic [1:0]  WBSel_w,
  output logic [4:0]  rd_w,
  output logic        illegal_w
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       load;
    logic       store;
    logic       branch;
    logic       jump;
    logic       wen;
    logic [1:0] wbsel;
    logic       asel;
    logic       bsel;
    logic [3:0] alusel;
    logic [2:0] immsel;
  } ctrl_t;

  ctrl_t      w_dec;
  ctrl_t      r_e;
  ctrl_t      r_m;
  ctrl_t      r_w;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_wr;
  logic       w_taken;
  logic       w_hazard;
  logic       w_unused;

  assign w_op = instr_d[6:0];
  assign w_f3 = instr_d[14:12];

  always_comb begin
    w_dec        = '0;
    w_wr         = 1'b0;
    w_dec.valid  = valid_d;
    w_dec.rs1    = instr_d[19:15];
    w_dec.rs2    = instr_d[24:20];
    w_dec.rd     = instr_d[11:7];
    w_dec.funct3 = w_f3;
    unique case (1'b1)
      (w_op == OP_R): begin
        w_dec.rs1_used = 1'b1;
        w_dec.rs2_used = 1'b1;
        w_dec.alusel   = {instr_d[30], w_f3};
        w_wr           = 1'b1;
      end
      (w_op == OP_IMM): begin
        w_dec.rs1_used = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.alusel   = {(w_f3 == 3'b101) & instr_d[30], w_f3};
        w_wr           = 1'b1;
      end
      (w_op == OP_LOAD): begin
        w_dec.rs1_used = 1'b1;
        w_dec.load     = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.wbsel    = 2'b01;
        w_wr           = 1'b1;
      end
      (w_op == OP_STORE): begin
        w_dec.rs1_used = 1'b1;
        w_dec.rs2_used = 1'b1;
        w_dec.store    = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.immsel   = 3'd4;
      end
      (w_op == OP_BRANCH): begin
        w_dec.rs1_used = 1'b1;
        w_dec.rs2_used = 1'b1;
        w_dec.branch   = 1'b1;
        w_dec.asel     = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.immsel   = 3'd1;
      end
      (w_op == OP_JAL): begin
        w_dec.jump   = 1'b1;
        w_dec.asel   = 1'b1;
        w_dec.bsel   = 1'b1;
        w_dec.wbsel  = 2'b10;
        w_dec.immsel = 3'd3;
        w_wr         = 1'b1;
      end
      (w_op == OP_JALR): begin
        w_dec.rs1_used = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.bsel     = 1'b1;
        w_dec.wbsel    = 2'b10;
        w_wr           = 1'b1;
      end
      (w_op == OP_LUI): begin
        w_dec.bsel   = 1'b1;
        w_dec.immsel = 3'd2;
        w_wr         = 1'b1;
      end
      (w_op == OP_AUIPC): begin
        w_dec.asel   = 1'b1;
        w_dec.bsel   = 1'b1;
        w_dec.immsel = 3'd2;
        w_wr         = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    // x0 writes are dropped here so later stages never see them
    w_dec.wen = w_wr & (w_dec.rd != 5'd0);
  end

  function automatic logic reads(input ctrl_t d,
                                 input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((d.rs1_used && d.rs1 == rd) ||
            (d.rs2_used && d.rs2 == rd));
  endfunction

  function automatic logic [1:0] fwd_src(input logic [4:0] rs,
                                         input ctrl_t m,
                                         input ctrl_t w);
    if (m.valid && m.wen && m.rd != 5'd0 && m.rd == rs)
      return 2'b01;
    if (w.valid && w.wen && w.rd != 5'd0 && w.rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN != 0) begin
      w_hazard = valid_d && r_e.valid && r_e.load &&
                 reads(w_dec, r_e.rd);
    end else begin
      w_hazard = valid_d &&
                 ((r_e.valid && r_e.wen && reads(w_dec, r_e.rd)) ||
                  (r_m.valid && r_m.wen && reads(w_dec, r_m.rd)));
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_e.funct3)
      3'b000:         w_taken = BrEq;
      3'b001:         w_taken = ~BrEq;
      3'b100, 3'b110: w_taken = BrLt;
      3'b101, 3'b111: w_taken = ~BrLt;
      default:        w_taken = 1'b0;
    endcase
  end

  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a_e = fwd_src(r_e.rs1, r_m, r_w);
      fwd_b_e = fwd_src(r_e.rs2, r_m, r_w);
    end
  end

  assign PCSel_e  = r_e.valid &
                    (r_e.jump | (r_e.branch & w_taken));
  assign flush_d  = PCSel_e;
  assign stall_fd = w_hazard & ~PCSel_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= (valid_d && !PCSel_e && !w_hazard) ? w_dec : '0;
      r_m <= r_e;
      r_w <= r_m;
    end
  end

  assign ImmSel_d  = w_dec.immsel;
  assign ASel_e    = r_e.asel;
  assign BSel_e    = r_e.bsel;
  assign ALUSel_e  = r_e.alusel;
  assign BrU_e     = r_e.funct3[2] & r_e.funct3[1];
  assign MemRW_m   = r_m.valid & r_m.store;
  assign RegWEn_w  = r_w.valid & r_w.wen;
  assign WBSel_w   = r_w.wbsel;
  assign rd_w      = r_w.rd;
  assign illegal_w = (ILL_FLAG_EN != 0) & r_w.valid & r_w.illegal;

  assign w_unused = ^{instr_d[31], instr_d[29:25], r_e, r_m, r_w};

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: stimulus queues cycle-tagged
// expectations, a monitor compares them mid-cycle.
module tb_pipe_control;

  localparam logic [31:0] ADDI1  = 32'h00500093;
  localparam logic [31:0] ADD2   = 32'h00108133;
  localparam logic [31:0] LW3    = 32'h00002183;
  localparam logic [31:0] ADD4   = 32'h00018233;
  localparam logic [31:0] BEQ    = 32'h00000463;
  localparam logic [31:0] BNE    = 32'h00001463;
  localparam logic [31:0] BLTU   = 32'h00006463;
  localparam logic [31:0] BGE    = 32'h00005463;
  localparam logic [31:0] BF2    = 32'h00002463;
  localparam logic [31:0] SRAI7  = 32'h4030D393;
  localparam logic [31:0] ADDIN  = 32'hC0000493;
  localparam logic [31:0] LUI8   = 32'h00001437;
  localparam logic [31:0] SW     = 32'h00102023;
  localparam logic [31:0] JAL1   = 32'h008000EF;
  localparam logic [31:0] ADDI0  = 32'h00100013;
  localparam logic [31:0] ILL    = 32'h0000007F;
  localparam logic [31:0] ADDI5  = 32'h00100293;
  localparam logic [31:0] SUB6   = 32'h40528333;

  typedef enum int {
    S_STALL, S_FLUSH, S_PCSEL, S_FWDA, S_FWDB, S_IMMSEL,
    S_ASEL, S_BSEL, S_BRU, S_ALUSEL, S_MEMRW, S_REGWEN,
    S_WBSEL, S_RDW, S_ILL,
    S0_STALL, S0_FLUSH, S0_PCSEL, S0_FWDA, S0_FWDB,
    S0_MEMRW, S0_REGWEN, S0_RDW, S_NUM
  } sig_e;

  typedef struct {
    int          cyc;
    int          ph;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d, instr0;
  logic        valid_d, valid0;
  logic        BrEq, BrLt;

  logic [2:0] imm_a, imm_b;
  logic       stall_a, stall_b, flush_a, flush_b;
  logic       asel_a, asel_b, bsel_a, bsel_b;
  logic       bru_a, bru_b, pcsel_a, pcsel_b;
  logic [3:0] alu_a, alu_b;
  logic [1:0] fa_a, fa_b, fb_a, fb_b;
  logic       mem_a, mem_b, wen_a, wen_b;
  logic [1:0] wb_a, wb_b;
  logic [4:0] rd_a, rd_b;
  logic       ill_a, ill_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipe_control #(.FWD_EN(1), .ILL_FLAG_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_d(instr_d), .valid_d(valid_d),
    .BrEq(BrEq), .BrLt(BrLt),
    .ImmSel_d(imm_a), .stall_fd(stall_a), .flush_d(flush_a),
    .ASel_e(asel_a), .BSel_e(bsel_a), .BrU_e(bru_a),
    .PCSel_e(pcsel_a), .ALUSel_e(alu_a),
    .fwd_a_e(fa_a), .fwd_b_e(fb_a),
    .MemRW_m(mem_a), .RegWEn_w(wen_a), .WBSel_w(wb_a),
    .rd_w(rd_a), .illegal_w(ill_a)
  );

  pipe_control #(.FWD_EN(0), .ILL_FLAG_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_d(instr0), .valid_d(valid0),
    .BrEq(BrEq), .BrLt(BrLt),
    .ImmSel_d(imm_b), .stall_fd(stall_b), .flush_d(flush_b),
    .ASel_e(asel_b), .BSel_e(bsel_b), .BrU_e(bru_b),
    .PCSel_e(pcsel_b), .ALUSel_e(alu_b),
    .fwd_a_e(fa_b), .fwd_b_e(fb_b),
    .MemRW_m(mem_b), .RegWEn_w(wen_b), .WBSel_w(wb_b),
    .rd_w(rd_b), .illegal_w(ill_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_STALL:   return {31'd0, stall_a};
      S_FLUSH:   return {31'd0, flush_a};
      S_PCSEL:   return {31'd0, pcsel_a};
      S_FWDA:    return {30'd0, fa_a};
      S_FWDB:    return {30'd0, fb_a};
      S_IMMSEL:  return {29'd0, imm_a};
      S_ASEL:    return {31'd0, asel_a};
      S_BSEL:    return {31'd0, bsel_a};
      S_BRU:     return {31'd0, bru_a};
      S_ALUSEL:  return {28'd0, alu_a};
      S_MEMRW:   return {31'd0, mem_a};
      S_REGWEN:  return {31'd0, wen_a};
      S_WBSEL:   return {30'd0, wb_a};
      S_RDW:     return {27'd0, rd_a};
      S_ILL:     return {31'd0, ill_a};
      S0_STALL:  return {31'd0, stall_b};
      S0_FLUSH:  return {31'd0, flush_b};
      S0_PCSEL:  return {31'd0, pcsel_b};
      S0_FWDA:   return {30'd0, fa_b};
      S0_FWDB:   return {30'd0, fb_b};
      S0_MEMRW:  return {31'd0, mem_b};
      S0_REGWEN: return {31'd0, wen_b};
      S0_RDW:    return {27'd0, rd_b};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_now(input int ph);
    logic [31:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc && sb[i].ph == ph) begin
        a = sample(sb[i].sig);
        checks++;
        if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d ph %0d got %0h want %0h",
                   sb[i].sig.name(), cyc, ph, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  always @(negedge clk) check_now(0);

  always @(negedge rst_n) begin
    #1;
    check_now(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp(input int k, input sig_e s,
                     input logic [31:0] v);
    sb.push_back('{cyc: cyc + k, ph: 0, sig: s, val: v});
  endtask

  task automatic exp_rst(input sig_e s, input logic [31:0] v);
    sb.push_back('{cyc: cyc, ph: 1, sig: s, val: v});
  endtask

  task automatic all_zero();
    for (int s = 0; s < S_NUM; s++) exp(0, sig_e'(s), 32'd0);
  endtask

  task automatic drv(input logic [31:0] ins, input logic v);
    instr_d = ins;
    valid_d = v;
  endtask

  task automatic drv0(input logic [31:0] ins, input logic v);
    instr0 = ins;
    valid0 = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(32'd0, 1'b0);
      drv0(32'd0, 1'b0);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drv(32'd0, 1'b0);
    drv0(32'd0, 1'b0);
    BrEq = 1'b0;
    BrLt = 1'b0;
    step(); all_zero();
    step(); all_zero();
    step();
    rst_n = 1'b1;

    // forward from M into both operands
    drv(ADDI1, 1'b1);
    exp(3, S_REGWEN, 1); exp(3, S_RDW, 1);
    step();
    drv(ADD2, 1'b1);
    exp(0, S_STALL, 0); exp(0, S_BSEL, 1);
    exp(3, S_REGWEN, 1); exp(3, S_RDW, 2);
    step();
    drv(32'd0, 1'b0);
    exp(0, S_FWDA, 1); exp(0, S_FWDB, 1);
    exp(0, S_BSEL, 0); exp(0, S_ALUSEL, 0);
    step();
    idle(3);

    // load-use: one stall, bubble, then W forward
    drv(LW3, 1'b1);
    exp(3, S_WBSEL, 1); exp(3, S_RDW, 3);
    step();
    drv(ADD4, 1'b1);
    exp(0, S_STALL, 1); exp(0, S_FLUSH, 0);
    step();
    drv(ADD4, 1'b1);
    exp(0, S_STALL, 0); exp(0, S_FWDA, 0);
    step();
    drv(32'd0, 1'b0);
    exp(0, S_FWDA, 2); exp(0, S_FWDB, 0);
    exp(0, S_REGWEN, 1); exp(1, S_REGWEN, 0);
    exp(2, S_REGWEN, 1); exp(2, S_RDW, 4);
    step();
    idle(3);

    // branches
    drv(BEQ, 1'b1);
    BrEq = 1'b1;
    step();
    drv(ADDI1, 1'b1);
    exp(0, S_PCSEL, 1); exp(0, S_FLUSH, 1);
    exp(0, S_STALL, 0); exp(0, S_ASEL, 1);
    exp(2, S_REGWEN, 0); exp(3, S_REGWEN, 0);
    step();
    drv(BNE, 1'b1);
    exp(0, S_PCSEL, 0);
    step();
    drv(32'd0, 1'b0);
    exp(0, S_PCSEL, 0); exp(0, S_FLUSH, 0); exp(0, S_BRU, 0);
    step();
    drv(BLTU, 1'b1);
    BrEq = 1'b0;
    BrLt = 1'b1;
    step();
    drv(32'd0, 1'b0);
    exp(0, S_PCSEL, 1); exp(0, S_BRU, 1);
    step();
    drv(BGE, 1'b1);
    step();
    drv(BF2, 1'b1);
    BrEq = 1'b1;
    exp(0, S_PCSEL, 0);
    step();
    drv(32'd0, 1'b0);
    exp(0, S_PCSEL, 0);
    step();
    BrEq = 1'b0;
    BrLt = 1'b0;
    idle(3);

    // decode formats, x0 write, illegal opcode
    drv(SRAI7, 1'b1);
    exp(0, S_IMMSEL, 0); exp(1, S_ALUSEL, 4'hD); exp(1, S_BSEL, 1);
    step();
    drv(ADDIN, 1'b1);
    exp(1, S_ALUSEL, 0);
    step();
    drv(LUI8, 1'b1);
    exp(0, S_IMMSEL, 2);
    step();
    drv(SW, 1'b1);
    exp(0, S_IMMSEL, 4); exp(2, S_MEMRW, 1); exp(3, S_REGWEN, 0);
    step();
    drv(JAL1, 1'b1);
    exp(0, S_IMMSEL, 3); exp(1, S_PCSEL, 1); exp(1, S_ASEL, 1);
    exp(3, S_WBSEL, 2); exp(3, S_RDW, 1); exp(3, S_REGWEN, 1);
    step();
    drv(32'd0, 1'b0);
    step();
    drv(ADDI0, 1'b1);
    exp(3, S_REGWEN, 0);
    step();
    drv(ILL, 1'b1);
    exp(0, S_IMMSEL, 0); exp(2, S_MEMRW, 0);
    exp(3, S_REGWEN, 0); exp(3, S_ILL, 1); exp(4, S_ILL, 0);
    step();
    idle(4);

    // no forwarding: RAW stalls for two cycles
    drv0(ADDI5, 1'b1);
    step();
    drv0(SUB6, 1'b1);
    exp(0, S0_STALL, 1); exp(0, S0_FWDA, 0); exp(0, S0_FWDB, 0);
    step();
    drv0(SUB6, 1'b1);
    exp(0, S0_STALL, 1);
    step();
    drv0(SUB6, 1'b1);
    exp(0, S0_STALL, 0); exp(0, S0_RDW, 5);
    step();
    drv0(32'd0, 1'b0);
    exp(0, S0_FWDA, 0); exp(0, S0_FWDB, 0);
    exp(2, S0_REGWEN, 1); exp(2, S0_RDW, 6);
    step();
    idle(3);

    // redirect beats a pending RAW stall
    drv0(JAL1, 1'b1);
    step();
    drv0(ADD2, 1'b1);
    exp(0, S0_PCSEL, 1); exp(0, S0_FLUSH, 1); exp(0, S0_STALL, 0);
    exp(2, S0_REGWEN, 1); exp(3, S0_REGWEN, 0);
    step();
    idle(4);

    // async reset with a store in M
    drv(SW, 1'b1);
    step();
    drv(32'd0, 1'b0);
    step();
    exp(0, S_MEMRW, 1);
    exp_rst(S_MEMRW, 0); exp_rst(S_REGWEN, 0);
    exp_rst(S_BSEL, 0); exp_rst(S_FWDA, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    step(); all_zero();
    step();
    rst_n = 1'b1;
    drv(ADDI1, 1'b1);
    exp(1, S_MEMRW, 0); exp(2, S_REGWEN, 0);
    exp(3, S_REGWEN, 1); exp(3, S_RDW, 1);
    step();
    idle(5);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL unchecked %s cyc %0d", sb[i].sig.name(), sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
